firtap_loader: RTL

//  Writer side of the FIR run-time tap-update chain (tap_wr / tap, one shift per write).

---
 rtl/firtap_loader.sv | 112 +++++++++++
 1 files changed

// File: rtl/firtap_loader.sv
// Tap loader for a run-time programmable FIR: the host fills a coefficient RAM, then on
// i_start the taps are streamed into the filter's shift chain, last tap first.
module firtap_loader #(
    parameter int NTAPS   = 128,
    parameter int TW      = 16,
    parameter int LGNTAPS = 7
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_wr,
    input  logic [LGNTAPS-1:0] i_addr,
    input  logic [TW-1:0]      i_data,
    output logic               o_wr_rej,
    input  logic               i_start,
    input  logic               i_stall,
    output logic               o_tap_wr,
    output logic [TW-1:0]      o_tap,
    output logic               o_busy,
    output logic               o_loaded
);

    localparam int                 AW      = $clog2(NTAPS);
    localparam logic [LGNTAPS:0]   LP_NTAP = NTAPS[LGNTAPS:0];
    localparam logic [LGNTAPS-1:0] LP_LAST = LGNTAPS'(NTAPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TW-1:0]      r_mem [NTAPS];
    logic [LGNTAPS-1:0] r_ptr_p0;
    logic [TW-1:0]      r_rd_p1;
    logic               r_vld_p1;
    logic [TW-1:0]      r_tap_last;
    logic               r_wr_rej;
    logic               r_loaded;
    logic               w_wr_ok;
    logic               w_start;
    logic               w_issue;
    logic               w_tap_wr;

    assign w_wr_ok = i_wr && (r_state == S_IDLE) && ({1'b0, i_addr} < LP_NTAP);
    assign w_start = i_start && (r_state == S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // A read is only issued on a non-stalled cycle, and on such a cycle any pending
    // tap is consumed, so the single output slot can never overflow.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_tap_wr    = r_vld_p1 && !i_stall;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_READ;
            end
            S_READ: begin
                if (!i_stall) begin
                    w_issue = 1'b1;
                    if (r_ptr_p0 == '0) w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_tap_wr) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Stage p0 -> p1: read pointer / control
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr_p0   <= '0;
            r_vld_p1   <= 1'b0;
            r_tap_last <= '0;
            r_wr_rej   <= 1'b0;
            r_loaded   <= 1'b0;
        end else begin
            r_wr_rej <= i_wr && !w_wr_ok;
            if (w_start)
                r_ptr_p0 <= LP_LAST;
            else if (w_issue && (r_ptr_p0 != '0))
                r_ptr_p0 <= r_ptr_p0 - 1'b1;
            if (w_issue)
                r_vld_p1 <= 1'b1;
            else if (w_tap_wr)
                r_vld_p1 <= 1'b0;
            if (w_tap_wr)
                r_tap_last <= r_rd_p1;
            if ((r_state == S_DRAIN) && w_tap_wr)
                r_loaded <= 1'b1;
            else if (w_wr_ok || w_start)
                r_loaded <= 1'b0;
        end
    end

    // Stage p1: coefficient RAM, registered read
    always_ff @(posedge i_clk) begin
        if (w_wr_ok) r_mem[i_addr[AW-1:0]] <= i_data;
        if (w_issue) r_rd_p1 <= r_mem[r_ptr_p0[AW-1:0]];
    end

    assign o_tap_wr = w_tap_wr;
    assign o_tap    = w_tap_wr ? r_rd_p1 : r_tap_last;
    assign o_busy   = (r_state != S_IDLE);
    assign o_loaded = r_loaded;
    assign o_wr_rej = r_wr_rej;

endmodule
